raw10_packet_4lane: RTL and testbench
=====================================

# raw10_packet_4lane

Transmit-side RAW10 packer for the 4-lane CSI path. It takes 4 pixels of 10 bits per beat and packs them into the MIPI RAW10 byte stream: per 4 pixels, four MSB bytes followed by one LSB byte. The stream leaves as 32-bit CSI words with valid/ready flow control, and each line is padded to a word boundary. It feeds the CSI TX long-packet builder and is the exact inverse of the RAW10 unpacker on the receive side.

## Interface
- `WC_WIDTH`, default 16: width of the line byte-count output.
- `I_clk` in 1: single clock.
- `I_rst` in 1: synchronous, active-high reset.
- `I_raw10_frame_start` in 1: single-cycle frame-start pulse.
- `I_raw10_frame_end` in 1: single-cycle frame-end pulse.
- `I_raw10_valid` in 1: pixel beat valid.
- `I_raw10_line_end` in 1: current beat is the last beat of the line; qualified by `I_raw10_valid`.
- `I_raw10_data` in 40: P0=[9:0], P1=[19:10], P2=[29:20], P3=[39:30], where P0 is first in time.
- `O_raw10_ready` out 1: beat accepted when valid && ready.
- `O_csi_frame_start` out 1: registered frame-start pulse.
- `O_csi_frame_end` out 1: frame-end pulse, emitted after the frame drains.
- `O_csi_valid` out 1: output word valid.
- `I_csi_ready` in 1: downstream accepts the word.
- `O_csi_data` out 32: byte k of the stream sits at [31-8*(k%4) -: 8], so the earliest byte is [31:24].
- `O_csi_last` out 1: marks the final word of the line.
- `O_line_wc` out WC_WIDTH: see Configuration.

## Operation
- **Group packing.** Each beat packs to 5 bytes: P0[9:2], P1[9:2], P2[9:2], P3[9:2], then {P3[1:0],P2[1:0],P1[1:0],P0[1:0]}.
- **Accumulator.** 8-byte accumulator `acc`; `cnt` = bytes held, range 0..8.
  - Push adds 5 bytes behind the held bytes.
  - Pop removes the oldest 4 bytes.
  - Push and pop in the same cycle: cnt' = cnt+1.
- **Ready.** `O_raw10_ready` = !I_rst && !flush && (cnt<4 || (cnt<8 && pop)), where pop = O_csi_valid && I_csi_ready.
- **Valid.** `O_csi_valid` = cnt>=4 || (flush && cnt>0).
- **Data.** `O_csi_data` is the oldest 4 bytes of `acc`. When flushing with cnt<4, the missing bytes are 0x00.
- **Flush state.**
  - Set when a beat with `I_raw10_line_end` is accepted.
  - While set, no input is accepted.
  - `O_csi_last` = flush && cnt<=4 && O_csi_valid.
  - Popping that word clears flush and cnt becomes 0.
- **States: IDLE / RUN / FLUSH.**
  - IDLE→RUN on the first accepted beat.
  - RUN→FLUSH on an accepted beat with line_end.
  - FLUSH→IDLE when the last word is popped.
- **Frame start.** `O_csi_frame_start` = I_raw10_frame_start delayed 1 cycle.
- **Frame end.**
  - `I_raw10_frame_end` sets a pending flag.
  - The pulse is emitted once, in the first cycle with pending && cnt==0 && !flush.
  - A frame_end arriving together with a line_end beat is therefore emitted only after the last word is popped.
- **Line length.** Any line of at least 1 beat (4 pixels) is legal. A line of N beats produces ceil(5N/4) words.

## Timing
- **Reset values.** All outputs 0; cnt=0; flush=0; pending=0; state IDLE.
  - Reset mid-line discards the partial data without emitting O_csi_last.
  - `O_raw10_ready` is 0 while I_rst is high.
- **Latency.** Beat accepted at edge N; the first word containing its bytes is valid from cycle N+1 if cnt>=4 after the push.
- **Throughput.** Sustained 4 beats per 5 words when I_csi_ready is held high.
- **Output hold.** While valid && !I_csi_ready, `O_csi_data` and `O_csi_last` stay stable.
- **Ready.** `O_raw10_ready` is combinational from registered state and I_csi_ready.

## Configuration
- `RAW10_PACK_WC_EN` defined:
  - `O_line_wc` is present.
  - It is valid with O_csi_last and equals 5×(beats in line), i.e. unpadded payload bytes, saturating at 2^WC_WIDTH-1.
  - The internal counter clears after the O_csi_last pop.
- `RAW10_PACK_WC_EN` undefined: the port and counter are absent.

## Structure
- **Package `raw10_pack_pkg`:**
  - Constants GROUP_BYTES=5, WORD_BYTES=4, ACC_BYTES=8.
  - State enum {IDLE, RUN, FLUSH}.
- **Sub-module `raw10_group_pack`:** combinational 40-bit pixel beat → 40-bit byte-ordered group, byte0 at [39:32].

## Test plan
- **Continuous line.** 4 beats of P0=0x3FF, P1=0x000, P2=0x155, P3=0x2AA with line_end on beat 4, ready high → exactly 5 words:
  - 0xFF0055AA, 0x93FF0055, 0xAA93FF00, 0x55AA93FF, 0x0055AA93.
  - O_csi_last on the 5th word; O_line_wc=20.
- **Padded single beat.** 1 beat of the same group with line_end → 0xFF0055AA, then 0x93000000 with O_csi_last; ready held 0 until the pad word is popped.
- **Backpressure.** Hold I_csi_ready=0 for 5 cycles mid-line → at most 1 further beat accepted (cnt=5, ready=0), data stable, no bytes lost or duplicated versus the golden stream.
- **Frame end with line end.** Frame_end asserted with the line_end beat of a 2-beat line → O_csi_frame_end pulses exactly once, on the cycle after the last word pop.
- **Reset mid-line.** I_rst for 1 cycle with cnt=6 → next cycle all outputs 0, cnt=0. A subsequent 4-beat line reproduces the scenario-1 words exactly.
- **Randomized regression.** Random valid/ready and line lengths 1–64 beats → output matches the unpacker round-trip, and every line ends with exactly one O_csi_last.

Source files
------------

// File: rtl/raw10_pack_pkg.sv
// Shared constants and state encoding for the RAW10 transmit packer.
package raw10_pack_pkg;

  localparam logic [3:0] GROUP_BYTES = 4'd5;
  localparam logic [3:0] WORD_BYTES  = 4'd4;
  localparam logic [3:0] ACC_BYTES   = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

endpackage

// File: rtl/raw10_group_pack.sv
// Packs one beat of four 10-bit pixels into a five-byte RAW10 group.
// The earliest byte of the group sits at [39:32].
module raw10_group_pack (
  input  logic [39:0] pixels,
  output logic [39:0] group
);

  // Four MSB bytes in pixel order, then the byte collecting all four LSB pairs
  always_comb begin
    group = {pixels[9:2], pixels[19:12], pixels[29:22], pixels[39:32],
             pixels[31:30], pixels[21:20], pixels[11:10], pixels[1:0]};
  end

endmodule

// File: rtl/raw10_packet_4lane.sv
// RAW10 packer for the 4-lane CSI transmit path: 4 pixels per beat in,
// 32-bit words out, each line padded with zero bytes to a word boundary.
// Optional feature: define RAW10_PACK_WC_EN to add the O_line_wc port,
// which reports the unpadded payload byte count of the line alongside O_csi_last.
module raw10_packet_4lane
  import raw10_pack_pkg::*;
`ifdef RAW10_PACK_WC_EN
  #(parameter int WC_WIDTH = 16)
`endif
  (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_raw10_frame_start,
  input  logic        I_raw10_frame_end,
  input  logic        I_raw10_valid,
  input  logic        I_raw10_line_end,
  input  logic [39:0] I_raw10_data,
  output logic        O_raw10_ready,
  output logic        O_csi_frame_start,
  output logic        O_csi_frame_end,
  output logic        O_csi_valid,
  input  logic        I_csi_ready,
  output logic [31:0] O_csi_data,
  output logic        O_csi_last
`ifdef RAW10_PACK_WC_EN
  , output logic [WC_WIDTH-1:0] O_line_wc
`endif
  );

  state_t      state, state_next;
  logic [63:0] acc, acc_next, base_acc;
  logic [3:0]  cnt, cnt_next, base_cnt;
  logic [39:0] group;
  logic        flush, push, pop, last_pop;
  logic        pending, frame_start_q;

  raw10_group_pack u_group_pack (
    .pixels (I_raw10_data),
    .group  (group)
  );

  // Handshake decode and line state transitions, all derived from registered state
  always_comb begin
    flush         = (state == FLUSH);
    O_csi_valid   = (cnt >= WORD_BYTES) || (flush && (cnt != 4'd0));
    pop           = O_csi_valid && I_csi_ready;
    O_csi_last    = flush && (cnt <= WORD_BYTES) && O_csi_valid;
    O_raw10_ready = !I_rst && !flush &&
                    ((cnt < WORD_BYTES) || ((cnt < ACC_BYTES) && pop));
    push          = I_raw10_valid && O_raw10_ready;
    last_pop      = pop && O_csi_last;
    state_next    = state;
    case (state)
      IDLE:    if (push) state_next = I_raw10_line_end ? FLUSH : RUN;
      RUN:     if (push && I_raw10_line_end) state_next = FLUSH;
      FLUSH:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Line state register
  always_ff @(posedge I_clk) begin
    if (I_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Accumulator update: retire the oldest word first, then append the new group
  // behind whatever remains; bytes past cnt are always zero, which supplies the pad
  always_comb begin
    base_acc = pop ? {acc[31:0], 32'h0} : acc;
    base_cnt = pop ? (cnt - WORD_BYTES) : cnt;
    acc_next = base_acc;
    cnt_next = base_cnt;
    if (last_pop) begin
      acc_next = '0;
      cnt_next = '0;
    end else if (push) begin
      acc_next = base_acc | ({group, 24'h0} >> {base_cnt, 3'b000});
      cnt_next = base_cnt + GROUP_BYTES;
    end
  end

  // Accumulator and byte-count registers
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
    end
  end

  assign O_csi_data      = acc[63:32];
  assign O_csi_frame_end = pending && (cnt == 4'd0) && !flush;

  // Frame markers: start is a one-cycle delay, end waits until the packer is empty
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      frame_start_q <= 1'b0;
      pending       <= 1'b0;
    end else begin
      frame_start_q <= I_raw10_frame_start;
      pending       <= (pending && !O_csi_frame_end) || I_raw10_frame_end;
    end
  end

  assign O_csi_frame_start = frame_start_q;

`ifdef RAW10_PACK_WC_EN
  localparam logic [WC_WIDTH-1:0] WC_MAX  = '1;
  localparam logic [WC_WIDTH-1:0] WC_STEP = WC_WIDTH'(GROUP_BYTES);

  logic [WC_WIDTH-1:0] wc_cnt;

  // Payload byte count of the current line, saturating, cleared once the line is out
  always_ff @(posedge I_clk) begin
    if (I_rst || last_pop) wc_cnt <= '0;
    else if (push)         wc_cnt <= (wc_cnt > (WC_MAX - WC_STEP)) ? WC_MAX : (wc_cnt + WC_STEP);
  end

  assign O_line_wc = wc_cnt;
`endif

endmodule

// File: tb/tb_raw10_packet_4lane.sv
// Scoreboard bench for raw10_packet_4lane: stimulus queues the expected
// words, a negedge monitor pops and compares every accepted output word.
module tb_raw10_packet_4lane;

  localparam logic [39:0] G = {10'h2AA, 10'h155, 10'h000, 10'h3FF};

  logic        I_clk = 1'b0;
  logic        I_rst;
  logic        I_raw10_frame_start;
  logic        I_raw10_frame_end;
  logic        I_raw10_valid;
  logic        I_raw10_line_end;
  logic [39:0] I_raw10_data;
  logic        O_raw10_ready;
  logic        O_csi_frame_start;
  logic        O_csi_frame_end;
  logic        O_csi_valid;
  logic        I_csi_ready;
  logic [31:0] O_csi_data;
  logic        O_csi_last;
`ifdef RAW10_PACK_WC_EN
  logic [15:0] O_line_wc;
`endif

  raw10_packet_4lane dut (
    .I_clk               (I_clk),
    .I_rst               (I_rst),
    .I_raw10_frame_start (I_raw10_frame_start),
    .I_raw10_frame_end   (I_raw10_frame_end),
    .I_raw10_valid       (I_raw10_valid),
    .I_raw10_line_end    (I_raw10_line_end),
    .I_raw10_data        (I_raw10_data),
    .O_raw10_ready       (O_raw10_ready),
    .O_csi_frame_start   (O_csi_frame_start),
    .O_csi_frame_end     (O_csi_frame_end),
    .O_csi_valid         (O_csi_valid),
    .I_csi_ready         (I_csi_ready),
    .O_csi_data          (O_csi_data),
    .O_csi_last          (O_csi_last)
`ifdef RAW10_PACK_WC_EN
    , .O_line_wc         (O_line_wc)
`endif
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          wc;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   assertCount = 0;
  int   failCount   = 0;
  int   cyc = 0;
  int   fePulses = 0;
  int   feCycle = -1;
  int   lastPopCycle = -1;
  logic holdValid = 1'b0;
  logic [31:0] holdData;
  logic holdLast;
  logic randReady = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic pushWord(input logic [31:0] d, input logic l, input int wc);
    exp_t e;
    e.data = d;
    e.last = l;
    e.wc   = wc;
    expQ.push_back(e);
  endtask

  // The four-beat reference line: five words, last one flagged, 20 bytes
  task automatic pushScenarioOne();
    pushWord(32'hFF0055AA, 1'b0, 0);
    pushWord(32'h93FF0055, 1'b0, 0);
    pushWord(32'hAA93FF00, 1'b0, 0);
    pushWord(32'h55AA93FF, 1'b0, 0);
    pushWord(32'h0055AA93, 1'b1, 20);
  endtask

  // Reference packing by byte list, as the receive-side unpacker expects it
  task automatic expectLine(input logic [39:0] beats[$]);
    logic [7:0] bytes[$];
    logic [9:0] p[4];
    int nw;
    foreach (beats[b]) begin
      for (int i = 0; i < 4; i++) p[i] = beats[b][10*i +: 10];
      for (int i = 0; i < 4; i++) bytes.push_back(p[i][9:2]);
      bytes.push_back({p[3][1:0], p[2][1:0], p[1][1:0], p[0][1:0]});
    end
    while ((bytes.size() % 4) != 0) bytes.push_back(8'h00);
    nw = bytes.size() / 4;
    for (int w = 0; w < nw; w++)
      pushWord({bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]},
               (w == nw - 1), 5 * beats.size());
  endtask

  // Present one beat and hold it until accepted; frame_end rides only the accepting cycle
  task automatic applyStimulus(input logic [39:0] d, input logic le, input logic fe);
    int t = 0;
    I_raw10_valid    = 1'b1;
    I_raw10_data     = d;
    I_raw10_line_end = le;
    @(negedge I_clk);
    while (!O_raw10_ready && t < 500) begin
      @(negedge I_clk);
      t++;
    end
    if (t >= 500) reportTimeout("beat_accept");
    I_raw10_frame_end = fe;
    @(posedge I_clk);
    #1;
    I_raw10_valid     = 1'b0;
    I_raw10_line_end  = 1'b0;
    I_raw10_frame_end = 1'b0;
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((expQ.size() != 0 || O_csi_valid) && t < 2000) begin
      @(negedge I_clk);
      t++;
    end
    if (t >= 2000) reportTimeout("drain");
    @(posedge I_clk);
    #1;
  endtask

  always @(posedge I_clk) cyc++;

  always @(posedge I_clk) begin
    if (randReady) begin
      #1;
      I_csi_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: hold stability under backpressure, frame-end tracking, word scoreboard
  always @(negedge I_clk) begin
    if (holdValid) begin
      checkOutput("hold_valid", O_csi_valid, 1);
      checkOutput("hold_data", O_csi_data, holdData);
      checkOutput("hold_last", O_csi_last, holdLast);
    end
    holdValid = O_csi_valid && !I_csi_ready && !I_rst;
    holdData  = O_csi_data;
    holdLast  = O_csi_last;
    if (O_csi_frame_end) begin
      fePulses++;
      feCycle = cyc;
    end
    if (O_csi_valid && I_csi_ready && !I_rst) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_word: got 0x%0h with nothing expected", O_csi_data);
      end else begin
        monE = expQ.pop_front();
        checkOutput("word_data", O_csi_data, monE.data);
        checkOutput("word_last", O_csi_last, monE.last);
`ifdef RAW10_PACK_WC_EN
        if (monE.last) checkOutput("line_wc", O_line_wc, monE.wc);
`endif
      end
      if (O_csi_last) lastPopCycle = cyc;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [39:0] beats[$];
    logic [63:0] r;
    int n;

    I_rst = 1'b1;
    I_raw10_frame_start = 1'b0;
    I_raw10_frame_end   = 1'b0;
    I_raw10_valid       = 1'b0;
    I_raw10_line_end    = 1'b0;
    I_raw10_data        = '0;
    I_csi_ready         = 1'b1;

    // Reset behaviour
    repeat (2) @(posedge I_clk);
    @(negedge I_clk);
    checkOutput("rst_ready", O_raw10_ready, 0);
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    @(negedge I_clk);
    checkOutput("rst_valid", O_csi_valid, 0);
    checkOutput("rst_last", O_csi_last, 0);
    checkOutput("rst_data", O_csi_data, 0);
    checkOutput("rst_fe", O_csi_frame_end, 0);
    checkOutput("rst_fs", O_csi_frame_start, 0);
    checkOutput("idle_ready", O_raw10_ready, 1);

    // Frame start is a one-cycle delayed copy
    @(posedge I_clk);
    #1;
    I_raw10_frame_start = 1'b1;
    @(negedge I_clk);
    checkOutput("fs_not_yet", O_csi_frame_start, 0);
    @(posedge I_clk);
    #1;
    I_raw10_frame_start = 1'b0;
    @(negedge I_clk);
    checkOutput("fs_pulse", O_csi_frame_start, 1);
    @(negedge I_clk);
    checkOutput("fs_end", O_csi_frame_start, 0);
    @(posedge I_clk);
    #1;

    // Continuous four-beat line
    $display("[TB] continuous line");
    pushScenarioOne();
    for (int b = 0; b < 4; b++) applyStimulus(G, (b == 3), 1'b0);
    waitDrain();

    // Single beat padded to two words; input blocked until the pad word leaves
    $display("[TB] padded single beat");
    pushWord(32'hFF0055AA, 1'b0, 0);
    pushWord(32'h93000000, 1'b1, 5);
    applyStimulus(G, 1'b1, 1'b0);
    @(negedge I_clk);
    checkOutput("pad_ready_a", O_raw10_ready, 0);
    @(negedge I_clk);
    checkOutput("pad_ready_b", O_raw10_ready, 0);
    @(negedge I_clk);
    checkOutput("pad_ready_c", O_raw10_ready, 1);
    waitDrain();

    // Backpressure for five cycles after the first beat
    $display("[TB] backpressure");
    I_csi_ready = 1'b0;
    pushScenarioOne();
    fork
      begin
        for (int b = 0; b < 4; b++) applyStimulus(G, (b == 3), 1'b0);
      end
      begin
        n = 0;
        @(negedge I_clk);
        while (!O_csi_valid && n < 50) begin
          @(negedge I_clk);
          n++;
        end
        if (n >= 50) reportTimeout("bp_valid");
        for (int k = 0; k < 5; k++) begin
          checkOutput("bp_ready", O_raw10_ready, 0);
          checkOutput("bp_data", O_csi_data, 32'hFF0055AA);
          @(negedge I_clk);
        end
        @(posedge I_clk);
        #1;
        I_csi_ready = 1'b1;
      end
    join
    waitDrain();

    // Frame end together with the line-end beat of a two-beat line
    $display("[TB] frame end with line end");
    fePulses = 0;
    pushWord(32'hFF0055AA, 1'b0, 0);
    pushWord(32'h93FF0055, 1'b0, 0);
    pushWord(32'hAA930000, 1'b1, 10);
    applyStimulus(G, 1'b0, 1'b0);
    applyStimulus(G, 1'b1, 1'b1);
    waitDrain();
    repeat (3) @(negedge I_clk);
    checkOutput("fe_count", fePulses, 1);
    checkOutput("fe_cycle", feCycle, lastPopCycle + 1);
    @(posedge I_clk);
    #1;

    // Reset with six bytes held, then a clean line
    $display("[TB] reset mid-line");
    pushWord(32'hFF0055AA, 1'b0, 0);
    applyStimulus(G, 1'b0, 1'b0);
    applyStimulus(G, 1'b0, 1'b0);
    I_csi_ready = 1'b0;
    I_rst       = 1'b1;
    @(negedge I_clk);
    checkOutput("midrst_ready", O_raw10_ready, 0);
    @(posedge I_clk);
    #1;
    I_rst = 1'b0;
    @(negedge I_clk);
    checkOutput("midrst_valid", O_csi_valid, 0);
    checkOutput("midrst_last", O_csi_last, 0);
    checkOutput("midrst_data", O_csi_data, 0);
    checkOutput("midrst_fe", O_csi_frame_end, 0);
    checkOutput("midrst_queue", expQ.size(), 0);
    checkOutput("midrst_in_ready", O_raw10_ready, 1);
    @(posedge I_clk);
    #1;
    I_csi_ready = 1'b1;
    pushScenarioOne();
    for (int b = 0; b < 4; b++) applyStimulus(G, (b == 3), 1'b0);
    waitDrain();

    // Random lengths, pixels, gaps and output backpressure
    $display("[TB] randomized lines");
    randReady = 1'b1;
    for (int l = 0; l < 6; l++) begin
      beats.delete();
      n = $urandom_range(1, 64);
      for (int b = 0; b < n; b++) begin
        r = {$urandom, $urandom};
        beats.push_back(r[39:0]);
      end
      expectLine(beats);
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge I_clk);
        #1;
        applyStimulus(beats[b], (b == n - 1), 1'b0);
      end
    end
    randReady = 1'b0;
    @(posedge I_clk);
    #2;
    I_csi_ready = 1'b1;
    waitDrain();
    checkOutput("final_queue", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
